// File: rtl/bsg_hash_bank_dispatch_pkg.sv
// Shared constants for the hash bank dispatcher: counter width and bank-select width helper.
package bsg_hash_bank_dispatch_pkg;

    localparam int cnt_width_lp = 32;

    function automatic int lg_banks(input int banks);
        return $clog2(banks);
    endfunction

endpackage

// File: rtl/bsg_hash_bank_dispatch_order_fifo.sv
// Order FIFO: circular buffer of dispatched bank ids, els_p deep, with an occupancy count.
// Latency: a pushed id is visible at head_data the cycle after the push.
// Backpressure: full comes from the registered count, so a same-cycle pop never frees room.
module bsg_hash_bank_dispatch_order_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [width_p-1:0] push_data,
    input  logic               pop,
    output logic [width_p-1:0] head_data,
    output logic               full,
    output logic               empty
);
    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp-1:0] wptr;
    logic [ptr_w_lp-1:0] rptr;
    logic [ptr_w_lp:0]   count;
    logic                do_push;
    logic                do_pop;

    assign full      = (count == (ptr_w_lp+1)'(els_p));
    assign empty     = (count == '0);
    assign head_data = mem[rptr];
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;

    // els_p is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + ptr_w_lp'(1);
            if (do_pop)  rptr <= rptr + ptr_w_lp'(1);
            if (do_push & ~do_pop)      count <= count + (ptr_w_lp+1)'(1);
            else if (do_pop & ~do_push) count <= count - (ptr_w_lp+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/bsg_hash_bank_dispatch.sv
// Hash bank dispatcher: routes requests to banks by top address bits, returns responses in request order.
// Latency: one cycle from input handshake to bank_v_o; responses pass through combinationally from the head bank.
// Backpressure: ready_o drops while the request register is held; counters exist only with BSG_HASH_BANK_DISPATCH_PERF_EN.
module bsg_hash_bank_dispatch
    import bsg_hash_bank_dispatch_pkg::*;
#(
    parameter int banks_p      = 2,
    parameter int width_p      = 128,
    parameter int data_width_p = 32,
    parameter int els_p        = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  v_i,
    input  logic [width_p-1:0]                    addr_i,
    output logic                                  ready_o,
    output logic [banks_p-1:0]                    bank_v_o,
    output logic [width_p-lg_banks(banks_p)-1:0]  bank_index_o,
    input  logic [banks_p-1:0]                    bank_ready_i,
    input  logic [banks_p-1:0]                    bank_resp_v_i,
    input  logic [banks_p*data_width_p-1:0]       bank_resp_data_i,
    output logic [banks_p-1:0]                    bank_resp_yumi_o,
    output logic                                  resp_v_o,
    output logic [data_width_p-1:0]               resp_data_o,
    input  logic                                  resp_yumi_i,
    output logic [cnt_width_lp-1:0]               stall_cnt_o,
    output logic [cnt_width_lp-1:0]               resp_cnt_o
);
    localparam int lg_banks_lp = lg_banks(banks_p);
    localparam int index_w_lp  = width_p - lg_banks_lp;

    typedef struct packed {
        logic [lg_banks_lp-1:0] bank;
        logic [index_w_lp-1:0]  index;
    } req_t;

    req_t                   req_r;
    logic                   req_full_r;
    logic                   dispatch;
    logic                   capture;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [lg_banks_lp-1:0] head;

    always_comb begin
        bank_v_o = '0;
        if (~reset_i & req_full_r & ~fifo_full) bank_v_o[req_r.bank] = 1'b1;
    end

    assign bank_index_o = req_r.index;
    assign dispatch     = |(bank_v_o & bank_ready_i);
    assign ready_o      = ~reset_i & (~req_full_r | dispatch);
    assign capture      = v_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i)       req_full_r <= 1'b0;
        else if (capture)  req_full_r <= 1'b1;
        else if (dispatch) req_full_r <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (capture) req_r <= req_t'(addr_i);
    end

    bsg_hash_bank_dispatch_order_fifo #(
        .els_p   (els_p),
        .width_p (lg_banks_lp)
    ) order_fifo (
        .clk       (clk_i),
        .reset     (reset_i),
        .push      (dispatch),
        .push_data (req_r.bank),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Only the head bank is visible; other banks' responses wait untouched
    assign resp_v_o = ~reset_i & ~fifo_empty & bank_resp_v_i[head];
    assign pop      = ~reset_i & ~fifo_empty & resp_yumi_i;

    always_comb begin
        resp_data_o      = '0;
        bank_resp_yumi_o = '0;
        for (int b = 0; b < banks_p; b++) begin
            if (head == lg_banks_lp'(b)) resp_data_o = bank_resp_data_i[b*data_width_p +: data_width_p];
        end
        bank_resp_yumi_o[head] = pop;
    end

`ifdef BSG_HASH_BANK_DISPATCH_PERF_EN
    logic [cnt_width_lp-1:0] stall_cnt;
    logic [cnt_width_lp-1:0] resp_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt <= '0;
            resp_cnt  <= '0;
        end else begin
            if (req_full_r & ~dispatch & ~&stall_cnt) stall_cnt <= stall_cnt + cnt_width_lp'(1);
            if (resp_yumi_i & ~&resp_cnt)             resp_cnt  <= resp_cnt + cnt_width_lp'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign resp_cnt_o  = resp_cnt;
`else
    assign stall_cnt_o = '0;
    assign resp_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_bsg_hash_bank_dispatch.sv
// Bench for bsg_hash_bank_dispatch (banks=2, width=8, els=4): directed stimulus with a queue-based scoreboard.
module tb_bsg_hash_bank_dispatch;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [7:0]  addr_i;
    logic        ready_o;
    logic [1:0]  bank_v_o;
    logic [6:0]  bank_index_o;
    logic [1:0]  bank_ready_i;
    logic [1:0]  bank_resp_v_i;
    logic [63:0] bank_resp_data_i;
    logic [1:0]  bank_resp_yumi_o;
    logic        resp_v_o;
    logic [31:0] resp_data_o;
    logic        resp_yumi_i;
    logic [31:0] stall_cnt_o;
    logic [31:0] resp_cnt_o;
    logic        yumi_en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] oh;
        logic [6:0] idx;
    } disp_t;

    disp_t       dq[$];
    logic [31:0] rq[$];

    bsg_hash_bank_dispatch #(
        .banks_p      (2),
        .width_p      (8),
        .data_width_p (32),
        .els_p        (4)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .addr_i           (addr_i),
        .ready_o          (ready_o),
        .bank_v_o         (bank_v_o),
        .bank_index_o     (bank_index_o),
        .bank_ready_i     (bank_ready_i),
        .bank_resp_v_i    (bank_resp_v_i),
        .bank_resp_data_i (bank_resp_data_i),
        .bank_resp_yumi_o (bank_resp_yumi_o),
        .resp_v_o         (resp_v_o),
        .resp_data_o      (resp_data_o),
        .resp_yumi_i      (resp_yumi_i),
        .stall_cnt_o      (stall_cnt_o),
        .resp_cnt_o       (resp_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // The consumer accepts any presented response while enabled
    assign resp_yumi_i = yumi_en & resp_v_o;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboards whenever a bank dispatch or a merged response handshake is seen
    always @(negedge clk_i) begin
        disp_t e;
        if (!reset_i) begin
            chk("bank_v_onehot", $onehot0(bank_v_o), 1);
            if ((bank_v_o & bank_ready_i) != 2'b00) begin
                if (dq.size() == 0) chk("unexpected_dispatch", bank_v_o, 0);
                else begin
                    e = dq.pop_front();
                    chk("dispatch_bank", bank_v_o, e.oh);
                    chk("dispatch_index", bank_index_o, e.idx);
                end
            end
            if (resp_v_o && resp_yumi_i) begin
                if (rq.size() == 0) chk("unexpected_resp", resp_data_o, 0);
                else chk("resp_data", resp_data_o, rq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [1:0] oh, input logic [6:0] idx);
        disp_t e;
        bit ok = 0;
        e.oh  = oh;
        e.idx = idx;
        dq.push_back(e);
        v_i    = 1'b1;
        addr_i = a;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk_i);
            if (ready_o) ok = 1;
        end
        if (!ok) chk("send_handshake_timeout", ok, 1);
        tick();
        v_i = 1'b0;
    endtask

    task automatic present(input int b, input logic [31:0] d);
        bank_resp_data_i[b*32 +: 32] = d;
        bank_resp_v_i[b] = 1'b1;
    endtask

    task automatic wait_yumi(input int b, input string name);
        bit seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk_i);
            if (bank_resp_yumi_o[b]) seen = 1;
        end
        chk(name, seen, 1);
        tick();
        bank_resp_v_i[b] = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) tick();
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset_i          = 1'b1;
        v_i              = 1'b0;
        addr_i           = '0;
        bank_ready_i     = 2'b11;
        bank_resp_v_i    = 2'b11;
        bank_resp_data_i = '0;
        yumi_en          = 1'b1;

        // Reset state with banks presenting responses and the consumer accepting
        repeat (3) tick();
        @(negedge clk_i);
        chk("rst_ready", ready_o, 0);
        chk("rst_bank_v", bank_v_o, 0);
        chk("rst_resp_v", resp_v_o, 0);
        chk("rst_bank_yumi", bank_resp_yumi_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_resp_cnt", resp_cnt_o, 0);
        tick();
        reset_i       = 1'b0;
        bank_resp_v_i = 2'b00;

        // Addr 0x85 goes to bank 1 with index 0x05, visible the cycle after the handshake
        send(8'h85, 2'b10, 7'h05);
        @(negedge clk_i);
        chk("lat_bank_v", bank_v_o, 2'b10);
        chk("lat_index", bank_index_o, 7'h05);
        rq.push_back(32'h0000_1234);
        present(1, 32'h0000_1234);
        wait_yumi(1, "s1_resp_timeout");

        // Bank 1 then bank 0; bank 0 answers first and must be held
        send(8'h92, 2'b10, 7'h12);
        send(8'h34, 2'b01, 7'h34);
        rq.push_back(32'hBB);
        rq.push_back(32'hAA);
        present(0, 32'hAA);
        repeat (3) begin
            @(negedge clk_i);
            chk("hold_bank0_yumi", bank_resp_yumi_o, 2'b00);
            chk("hold_resp_v", resp_v_o, 0);
            tick();
        end
        present(1, 32'hBB);
        wait_yumi(1, "s2_bank1_timeout");
        wait_yumi(0, "s2_bank0_timeout");

        // Four outstanding fill the order FIFO; the fifth waits until one pop, then goes a cycle later
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 2'b01, 7'(i));
            rq.push_back(32'hC0DE_0000 + 32'(i));
        end
        repeat (3) begin
            @(negedge clk_i);
            chk("full_bank_v", bank_v_o, 2'b00);
            chk("full_ready", ready_o, 0);
            tick();
        end
        present(0, 32'hC0DE_0001);
        @(negedge clk_i);
        chk("pop_cycle_yumi", bank_resp_yumi_o, 2'b01);
        chk("pop_cycle_bank_v", bank_v_o, 2'b00);
        tick();
        bank_resp_v_i[0] = 1'b0;
        @(negedge clk_i);
        chk("resume_bank_v", bank_v_o, 2'b01);
        chk("resume_index", bank_index_o, 7'h05);
        tick();
        for (int i = 2; i <= 5; i++) begin
            present(0, 32'hC0DE_0000 + 32'(i));
            wait_yumi(0, "s3_drain_timeout");
        end

        // Streaming: alternating banks, responses always available, one request per cycle
        bank_resp_data_i = {32'h5111_1111, 32'h5000_0000};
        bank_resp_v_i    = 2'b11;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 1) begin
                send(8'h80 | 8'(i), 2'b10, 7'(i));
                rq.push_back(32'h5111_1111);
            end else begin
                send(8'(i), 2'b01, 7'(i));
                rq.push_back(32'h5000_0000);
            end
        end
        chk("stream_cycles", cyc - t0, 10);
        for (int k = 0; k < 20 && rq.size() != 0; k++) tick();
        chk("stream_drained", rq.size(), 0);
        bank_resp_v_i = 2'b00;

        // Stall accounting: request held while its bank is not ready
        do_reset();
        bank_ready_i = 2'b00;
        send(8'h47, 2'b01, 7'h47);
        repeat (3) begin
            @(negedge clk_i);
            chk("stall_ready", ready_o, 0);
            tick();
        end
        @(negedge clk_i);
`ifdef BSG_HASH_BANK_DISPATCH_PERF_EN
        chk("stall_cnt", stall_cnt_o, 3);
`else
        chk("stall_cnt", stall_cnt_o, 0);
`endif
        bank_ready_i = 2'b11;
        tick();
        rq.push_back(32'h3434);
        present(0, 32'h3434);
        wait_yumi(0, "s4_resp_timeout");
        @(negedge clk_i);
`ifdef BSG_HASH_BANK_DISPATCH_PERF_EN
        chk("resp_cnt", resp_cnt_o, 1);
`else
        chk("resp_cnt", resp_cnt_o, 0);
`endif
        tick();

        // Reset with two outstanding requests drops them
        send(8'h81, 2'b10, 7'h01);
        send(8'h02, 2'b01, 7'h02);
        repeat (3) tick();
        reset_i       = 1'b1;
        bank_resp_v_i = 2'b11;
        repeat (2) begin
            @(negedge clk_i);
            chk("midrst_resp_v", resp_v_o, 0);
            chk("midrst_ready", ready_o, 0);
            chk("midrst_bank_v", bank_v_o, 0);
            chk("midrst_yumi", bank_resp_yumi_o, 0);
            tick();
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("postrst_resp_v", resp_v_o, 0);
        chk("postrst_ready", ready_o, 1);
        chk("postrst_stall_cnt", stall_cnt_o, 0);
        tick();
        bank_resp_v_i = 2'b00;

        repeat (2) tick();
        chk("dispatch_queue_empty", dq.size(), 0);
        chk("resp_queue_empty", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_hash_bank_dispatch.md
BSG_HASH_BANK_DISPATCH -- requirements
Module: bsg_hash_bank_dispatch

Interface
REQ-001 Parameter banks_p, default 2: number of banks; SHALL be a power of two, >= 2; lg_banks_lp = log2(banks_p).
REQ-002 Parameter width_p, default 128: request address width; SHALL be > lg_banks_lp.
REQ-003 Parameter data_width_p, default 32: response data width.
REQ-004 Parameter els_p, default 4: maximum outstanding requests; SHALL be a power of two, >= 2.
REQ-005 Port clk_i  in  1: single clock; all state changes on rising edge.
REQ-006 Port reset_i  in  1: synchronous, active-high reset.
REQ-007 Ports v_i in 1, addr_i in width_p, ready_o out 1: request input, valid/ready handshake.
REQ-008 Ports bank_v_o out banks_p (one-hot or zero), bank_index_o out width_p-lg_banks_lp, bank_ready_i in banks_p: per-bank request channel; bank_index_o is shared by all banks.
REQ-009 Ports bank_resp_v_i in banks_p, bank_resp_data_i in banks_p*data_width_p, bank_resp_yumi_o out banks_p: per-bank response channel, valid/yumi.
REQ-010 Ports resp_v_o out 1, resp_data_o out data_width_p, resp_yumi_i in 1: merged in-order response, valid/yumi.
REQ-011 Ports stall_cnt_o out 32, resp_cnt_o out 32: performance counters (see Configuration).

Function
REQ-012 Bank decode SHALL be bank = addr top lg_banks_lp bits; index = remaining low bits, unmodified.
REQ-013 One-entry request register SHALL capture addr_i when v_i & ready_o.
REQ-014 ready_o SHALL be ~req_full_r | dispatch; it SHALL NOT depend combinationally on v_i or addr_i.
REQ-015 bank_v_o[b] SHALL be 1 only when req_full_r, the register's bank is b, and the order FIFO is not full.
REQ-016 Dispatch SHALL occur when bank_v_o[b] & bank_ready_i[b]; this clears req_full_r unless a new request is captured in the same cycle.
REQ-017 On dispatch, the bank id SHALL be pushed into the order FIFO (depth els_p).
REQ-018 The full test SHALL use the registered count; a pop in the same cycle SHALL NOT allow a push when the FIFO is full.
REQ-019 resp_v_o SHALL be FIFO-not-empty & bank_resp_v_i[head]; resp_data_o SHALL be bank_resp_data_i[head].
REQ-020 bank_resp_yumi_o[head] SHALL equal resp_yumi_i; all other bits SHALL be 0.
REQ-021 resp_yumi_i SHALL pop the FIFO; a response from a non-head bank SHALL be held, not consumed.
REQ-022 Simultaneous push and pop SHALL leave the count unchanged; read and write pointers SHALL wrap modulo els_p.
REQ-023 Dispatch latency SHALL be 1 cycle minimum from input handshake to bank_v_o.
REQ-024 Responses SHALL be returned in request order regardless of bank response order.

Reset
REQ-025 While reset_i is high, ready_o, bank_v_o, bank_resp_yumi_o and resp_v_o SHALL be 0.
REQ-026 Reset SHALL clear req_full_r, FIFO pointers, count and both counters; mid-operation reset SHALL drop any in-flight request and ordering state.

Configuration
REQ-027 With macro BSG_HASH_BANK_DISPATCH_PERF_EN defined, stall_cnt_o SHALL count cycles with req_full_r & ~dispatch, and resp_cnt_o SHALL count resp_yumi_i; both SHALL saturate at 2^32-1.
REQ-028 Without the macro, both counters SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-029 Package bsg_hash_bank_dispatch_pkg SHALL hold the counter width (32) and a lg_banks helper constant/function.
REQ-030 The order FIFO SHALL be a sub-module bsg_hash_bank_dispatch_order_fifo (els_p x lg_banks_lp circular buffer with count).

Verification (banks_p=2, width_p=8, els_p=4)
REQ-031 Scenario: after reset, addr 0x85 with bank_ready_i=2'b11 -> next cycle bank_v_o=2'b10 and bank_index_o=0x05.
REQ-032 Scenario: issue to bank1, then bank0; bank0 responds first with 0xAA, bank1 later with 0xBB -> resp_data_o is 0xBB then 0xAA; bank0 is not yumi'd early.
REQ-033 Scenario: 4 dispatches with no responses -> 5th request is held, bank_v_o=0; one pop -> dispatch resumes on the next cycle, not the same cycle.
REQ-034 Scenario: bank_ready_i=0 for 3 cycles with a request held -> ready_o=0 and stall_cnt_o=3 with PERF_EN defined; stall_cnt_o=0 without it.
REQ-035 Scenario: back-to-back streaming with all banks ready and responses immediate -> 1 request per cycle sustained; pointers wrap past 3 correctly.
REQ-036 Scenario: reset_i asserted with 2 outstanding requests -> resp_v_o=0 and ready_o=0 during reset; count is 0 after reset.
